// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline types for the hazard sequencer: forward selects, shadow entries, FSM states.
package hazard_ctrl_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [1:0] {
        RD      = 2'd0,
        ALUOUTE = 2'd1,
        ALUOUTM = 2'd2,
        MEMDATA = 2'd3
    } fwd_sel_t;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] dst;
        logic              wb;
        logic              load;
    } haz_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } haz_state_t;

    // True when a shadow entry will write register ra.
    function automatic logic entry_hits(haz_entry_t ent, logic [REG_AW-1:0] ra);
        return ent.v & ent.wb & (ent.dst == ra);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side bundle between the decode stage (master) and the hazard sequencer (slave).
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic              d_valid;
    logic [REG_AW-1:0] ra1;
    logic [REG_AW-1:0] ra2;
    logic              use_ra1;
    logic              use_ra2;
    logic [REG_AW-1:0] d_dst;
    logic              d_wb;
    logic              d_load;
    logic              branch;
    logic              i_busy;
    logic              d_busy;

    fwd_sel_t          fwd_a;
    fwd_sel_t          fwd_b;
    logic              stall_f;
    logic              stall_d;
    logic              stall_e;
    logic              stall_m;
    logic              flush_d;
    logic              flush_e;
    logic              pc_redirect;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output d_valid, ra1, ra2, use_ra1, use_ra2, d_dst, d_wb, d_load,
               branch, i_busy, d_busy,
        input  fwd_a, fwd_b, stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, pc_redirect, stall_cnt
    );

    modport slave (
        input  d_valid, ra1, ra2, use_ra1, use_ra2, d_dst, d_wb, d_load,
               branch, i_busy, d_busy,
        output fwd_a, fwd_b, stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, pc_redirect, stall_cnt
    );

endinterface

// File: rtl/hazard_ctrl_fwd_select.sv
// Per-operand forwarding select from the Execute/Memory shadow entries; youngest producer wins.
module fwd_select
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] ra,
    input  logic              use_ra,
    input  haz_entry_t        ent_e,
    input  haz_entry_t        ent_m,
    output fwd_sel_t          sel_c
);

    always_comb begin
        sel_c = RD;
        if ((ra == '0) || !use_ra) begin
            sel_c = RD;
        end else if (entry_hits(ent_e, ra)) begin
            sel_c = ALUOUTE;
        end else if (entry_hits(ent_m, ra)) begin
            sel_c = ent_m.load ? MEMDATA : ALUOUTM;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer beside decode: shadow E/M record, forwarding selects, stall/flush,
// branch-redirect tracking across busy instruction fetches, and a saturating stall counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    hazard_ctrl_if.slave hz
);

    haz_entry_t       ent_e;
    haz_entry_t       ent_m;
    haz_state_t       state;
    haz_state_t       state_nxt;
    logic [CNT_W-1:0] stall_cnt_q;

    fwd_sel_t fwd_a_c;
    fwd_sel_t fwd_b_c;
    logic     load_use_c;
    logic     stall_f_c;
    logic     stall_d_c;
    logic     stall_e_c;
    logic     stall_m_c;
    logic     flush_d_c;
    logic     flush_e_c;
    logic     redirect_c;

    fwd_select u_fwd_a (
        .ra     (hz.ra1),
        .use_ra (hz.use_ra1),
        .ent_e  (ent_e),
        .ent_m  (ent_m),
        .sel_c  (fwd_a_c)
    );

    fwd_select u_fwd_b (
        .ra     (hz.ra2),
        .use_ra (hz.use_ra2),
        .ent_e  (ent_e),
        .ent_m  (ent_m),
        .sel_c  (fwd_b_c)
    );

    // A load in Execute feeding an operand decode actually reads.
    assign load_use_c = ent_e.load & (ent_e.dst != '0) &
                        ((hz.use_ra1 & entry_hits(ent_e, hz.ra1)) |
                         (hz.use_ra2 & entry_hits(ent_e, hz.ra2)));

    // Next state and stage controls; d_busy freezes everything, reset forces all controls low.
    always_comb begin
        state_nxt  = state;
        stall_f_c  = 1'b0;
        stall_d_c  = 1'b0;
        stall_e_c  = 1'b0;
        stall_m_c  = 1'b0;
        flush_d_c  = 1'b0;
        flush_e_c  = 1'b0;
        redirect_c = 1'b0;
        if (!reset) begin
            state_nxt = RUN;
        end else if (hz.d_busy) begin
            stall_f_c = 1'b1;
            stall_d_c = 1'b1;
            stall_e_c = 1'b1;
            stall_m_c = 1'b1;
        end else begin
            if (load_use_c) begin
                stall_f_c = 1'b1;
                stall_d_c = 1'b1;
                flush_e_c = 1'b1;
            end
            // A held decode instruction must not be replaced by the fetch bubble.
            if (hz.i_busy) begin
                stall_f_c = 1'b1;
                flush_d_c = !load_use_c;
            end
            unique case (state)
                RUN: begin
                    if (hz.branch && !load_use_c) begin
                        if (hz.i_busy) begin
                            state_nxt = PEND;
                        end else begin
                            redirect_c = 1'b1;
                            flush_d_c  = 1'b1;
                        end
                    end
                end
                PEND: begin
                    stall_f_c = 1'b1;
                    flush_d_c = 1'b1;
                    if (!hz.i_busy) begin
                        redirect_c = 1'b1;
                        state_nxt  = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Shadow record advances with the pipe unless data memory freezes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_e <= '0;
            ent_m <= '0;
        end else if (!hz.d_busy) begin
            ent_e <= '{v:    hz.d_valid & ~flush_e_c,
                       dst:  hz.d_dst,
                       wb:   hz.d_wb,
                       load: hz.d_load};
            ent_m <= ent_e;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall_d_c && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign hz.fwd_a       = fwd_a_c;
    assign hz.fwd_b       = fwd_b_c;
    assign hz.stall_f     = stall_f_c;
    assign hz.stall_d     = stall_d_c;
    assign hz.stall_e     = stall_e_c;
    assign hz.stall_m     = stall_m_c;
    assign hz.flush_d     = flush_d_c;
    assign hz.flush_e     = flush_e_c;
    assign hz.pc_redirect = redirect_c;
    assign hz.stall_cnt   = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage core; sits beside decode.
- Keeps its own shadow record of the instructions in Execute and Memory, and from it drives the decode forwarding selects (the `sctlD.ac`/`sctlD.bc` fields).
- Generates per-stage stall and flush, tracks branch redirects that land while instruction memory is busy, and counts stall cycles.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, stall-counter width.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low (0 = reset).
- d_valid  in  1  decode holds a valid instruction.
- ra1, ra2  in  REG_AW  decode source registers.
- use_ra1, use_ra2  in  1  decode instruction reads ra1/ra2.
- d_dst  in  REG_AW  decode destination.
- d_wb  in  1  decode instruction writes a register.
- d_load  in  1  decode instruction is a load.
- branch  in  1  decode resolved a taken branch/jump.
- i_busy  in  1  imem request outstanding.
- d_busy  in  1  dmem request outstanding.
- fwd_a, fwd_b  out  2  forward select: RD=0, ALUOUTE=1, ALUOUTM=2, MEMDATA=3.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the stage register.
- flush_d, flush_e  out  1  load a bubble into the D / E register.
- pc_redirect  out  1  fetch takes PCbranch this cycle.
- stall_cnt  out  CNT_W  cycles with stall_d=1.

Behaviour:
- Shadow entries E and M, each holding {v, dst, wb, load}; reset clears v.
- Advance rule, unless frozen:
  - E <= decode fields, with v = d_valid & ~flush_e.
  - M <= E.
  - Retire M.
- Freeze when d_busy=1: the E/M entries hold.
- Forwarding for each operand (a shown; b identical). Combinational, first match wins:
  - ra1==0 or !use_ra1 -> RD.
  - E.v & E.wb & E.dst==ra1 -> ALUOUTE.
  - M.v & M.wb & M.dst==ra1 -> MEMDATA if M.load, else ALUOUTM.
  - Otherwise RD.
- load_use = E.v & E.load & E.wb & E.dst!=0 & (E.dst matches an operand in use).
  - Result: stall_f = stall_d = 1, flush_e = 1 (bubble), branch ignored this cycle.
- d_busy=1:
  - stall_f = stall_d = stall_e = stall_m = 1.
  - All flushes 0; no redirect.
  - Dominates load_use and i_busy.
  - stall_cnt still increments.
- i_busy=1 (and d_busy=0):
  - stall_f = 1.
  - flush_d = 1, so decode receives a bubble next cycle.
  - Older stages proceed.
- FSM states RUN and PEND (reset -> RUN).
  - RUN, branch & ~load_use & ~d_busy:
    - If ~i_busy: pc_redirect = 1, flush_d = 1, stay in RUN.
    - If i_busy: go to PEND. The in-flight fetch is wrong-path; the target is held by fetch.
  - PEND:
    - stall_f = 1, flush_d = 1 every cycle; further branch inputs ignored.
    - When i_busy falls: pc_redirect = 1, discard that fetch (flush_d = 1), return to RUN.
- stall_cnt:
  - Increments by 1 each cycle stall_d=1.
  - Saturates at all-ones (no wrap); reset 0.
- Reset values (reset asserted, mid-operation included):
  - FSM = RUN; E.v = M.v = 0; stall_cnt = 0.
  - Every output 0 except fwd_a = fwd_b = RD (0).
- Decode's own ra==0 path needs no special case: when registers are 0, the first forwarding rule always selects RD.

Decomposition:
- Add to the shared pipes package:
  - the fwd_sel_t enum (RD, ALUOUTE, ALUOUTM, MEMDATA; the type of `sctlD.ac`/`sctlD.bc`);
  - the shadow-entry struct haz_entry_t {v, dst, wb, load};
  - the FSM enum haz_state_t.
- One sub-module, fwd_select: combinational, one instance per operand (ra, use_ra, E entry, M entry -> fwd_sel_t).

Test Plan:
- Forwarding priority: E = {v1, dst 5, wb1, ld0}, M = {v1, dst 5, wb1, ld0}, decode ra1=5 use_ra1 -> fwd_a=ALUOUTE; E.v=0 -> ALUOUTM; set M.load=1 -> MEMDATA; ra1=0 -> RD.
- Load-use: load to x7 in E, decode use_ra2 with ra2=7 -> one cycle of stall_f=stall_d=flush_e=1; next cycle load in M, fwd_b=MEMDATA; stall_cnt=1.
- Taken branch with i_busy=0 -> pc_redirect=1 and flush_d=1 for exactly one cycle; FSM stays RUN.
- Branch with i_busy=1 held 3 cycles -> PEND for 3 cycles (stall_f=flush_d=1, pc_redirect=0), then one cycle pc_redirect=1, then RUN.
- d_busy=1 for 4 cycles during load-use + branch -> all four stalls 1, flush/redirect 0, E/M contents unchanged, stall_cnt +4; load-use resolves after d_busy drops.
- Assert reset while in PEND with E/M valid -> immediately FSM=RUN, all outputs 0, stall_cnt=0.
